digital_transmitter: RTL and testbench
======================================

# digital_transmitter

Serial telemetry transmitter that produces the dCLK/dDAT/dFM triplet consumed by the digital receiver on the far end of the same link. It takes bytes from an upstream byte source over a valid/ready handshake and sends them MSB-first as frames of 10240 bits. Each frame opens with a dFM pulse and a quiet gap. A further quiet gap follows every 2816 bits, so the receiver has time to insert its 44-bit marker between segments. Everything runs on the 240 MHz system clock.

## Interface
- HALF, 12: dCLK half-period in clk240 cycles; minimum 4, because the receiver samples dDAT up to 3 cycles after dCLK falls.
- FM_CYCLES, 24: dFM high time in clk240 cycles.
- GAP_CYCLES, 128: quiet time after dFM falls and after each segment; minimum 100, the receiver's marker-write time.
- FRAME_BITS, 10240: bits per frame; must be a multiple of 8.
- SEG_BITS, 2816: bits per segment before a segment gap.
- clk240  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a frame; honoured only in IDLE.
- txData  in  8  byte to send, MSB first.
- txValid  in  1  txData is valid.
- txReady  out  1  combinational, high only in FETCH; a byte transfers on an edge where txValid and txReady are both high.
- dCLK  out  1  serial clock, registered.
- dDAT  out  1  serial data, registered; changes only on the dCLK rising edge.
- dFM  out  1  frame marker, registered.
- busy  out  1  high in every state except IDLE.
- frameDone  out  1  one-cycle pulse after the last bit of a frame.
- underrun  out  1  sticky; set when FETCH is entered and waits at least 1 cycle with txValid low; cleared by rst or by an accepted start.

## Operation
- States and transitions:
  - IDLE: start leads to SYNC.
  - SYNC: dFM=1 for FM_CYCLES cycles, then PRE_GAP.
  - PRE_GAP: all outputs low for GAP_CYCLES cycles, then FETCH.
  - FETCH: waits for the handshake, then BIT_HI.
  - BIT_HI: dCLK=1 for HALF cycles, then BIT_LO.
  - BIT_LO: dCLK=0 for HALF cycles, then one of:
    - BIT_HI if bits remain in the current byte;
    - FETCH if the byte is done and the frame is not;
    - SEG_GAP if the bit count is a nonzero multiple of SEG_BITS and below FRAME_BITS;
    - IDLE if the bit count equals FRAME_BITS, with frameDone pulsing.
  - SEG_GAP: dCLK=0 and dFM=0 for GAP_CYCLES cycles, then FETCH.
- On the accepting edge in FETCH: the 8-bit shift register loads txData, dDAT<=txData[7], dCLK<=1.
- On each BIT_LO to BIT_HI edge: dDAT<=the next shift bit, dCLK<=1.
- The bit counter is 14 bits wide. It increments on each BIT_HI to BIT_LO edge (the dCLK falling edge) and clears on start.
- The byte bit index is 3 bits wide and wraps 7 to 0.
- The phase counter is 8 bits wide and reloads on every state entry.
- Underrun: dCLK holds low in FETCH and the stream stalls. No filler bits are inserted.
- start while busy: ignored.
- rst mid-frame: every output takes its reset value on the next edge, the state returns to IDLE, and the partial frame is abandoned.
- Reset values: dCLK=0, dDAT=0, dFM=0, txReady=0, busy=0, frameDone=0, underrun=0.
- dDAT holds its last value through BIT_LO, FETCH, the gaps and IDLE. It returns to 0 only on rst or start.

## Timing
- Edge 0 samples start: dFM=1 during cycles 1..FM_CYCLES, then low for GAP_CYCLES; with the defaults, txReady first rises in cycle 153.
- Per bit: HALF cycles high, then HALF cycles low. The falling dCLK edge falls mid-bit, and dDAT is stable for the whole low phase.
- Per byte, with txValid held high: 16*HALF+1 cycles, where the +1 is the FETCH cycle with dCLK low. With the defaults that is 193 cycles.
- A segment gap adds GAP_CYCLES+1 low cycles, including FETCH.
- A full frame with defaults and no stalls: 24+128+1280*193+3*128 = 247576 cycles from start to frameDone.
- frameDone asserts on the edge that ends the last BIT_LO. busy falls on the same edge.
- Between frames dCLK and dFM remain low, and a new start may be applied on the cycle after frameDone.

## Test plan
- Reset, then start with txValid tied high and txData=8'hA5:
  - dFM is high for exactly 24 cycles, then 128 quiet cycles;
  - dDAT sampled on dCLK falling edges gives 1,0,1,0,0,1,0,1 repeating;
  - bit period is 24 cycles.
- Full frame of incrementing bytes, decoded by a bench model of the receiver (3-stage dCLK sync, sampling on the detected falling edge):
  - 10240 bits, byte n = n mod 256;
  - exactly 3 gaps of ≥128 low cycles, after bits 2816, 5632 and 8448;
  - frameDone asserts exactly once, at cycle 247576.
- Drop txValid for 500 cycles at byte 10:
  - dCLK stays low for the whole stall and underrun becomes 1;
  - the data sequence continues unbroken after txValid returns;
  - underrun stays 1 until the next accepted start.
- Pulse start again mid-frame: no effect; the bit count and outputs stay identical to an undisturbed run.
- Assert rst during bit 3000 (inside segment 2):
  - next cycle dCLK=dDAT=dFM=busy=0;
  - a fresh start then produces a complete, correct frame.
- Set HALF=4 and GAP_CYCLES=100: the receiver model still decodes all 10240 bits correctly and misses no falling edges.

Source files
------------

// File: rtl/digital_transmitter.sv
// digital_transmitter
// Serial telemetry transmitter producing the dCLK/dDAT/dFM triplet for the
// far-end digital receiver. Bytes arrive over a valid/ready handshake and
// are sent MSB-first in frames of FRAME_BITS bits. Each frame opens with a
// dFM pulse and a quiet gap. A further quiet gap follows every SEG_BITS
// bits, which gives the receiver time to insert its segment marker.
//
// Ports
//   clk240     in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a frame (honoured only when idle)
//   txData     in   byte to send, MSB first
//   txValid    in   txData is valid
//   txReady    out  combinational, high while waiting for the next byte
//   dCLK       out  serial clock (registered)
//   dDAT       out  serial data (registered, changes on dCLK rise only)
//   dFM        out  frame marker (registered)
//   busy       out  high whenever a frame is in progress
//   frameDone  out  one-cycle pulse after the last bit of a frame
//   underrun   out  sticky: the byte source kept the link waiting
module digital_transmitter #(
  parameter int HALF       = 12,
  parameter int FM_CYCLES  = 24,
  parameter int GAP_CYCLES = 128,
  parameter int FRAME_BITS = 10240,
  parameter int SEG_BITS   = 2816
) (
  input  logic       clk240,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       dCLK,
  output logic       dDAT,
  output logic       dFM,
  output logic       busy,
  output logic       frameDone,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PRE_GAP = 3'd2,
    FETCH   = 3'd3,
    BIT_HI  = 3'd4,
    BIT_LO  = 3'd5,
    SEG_GAP = 3'd6
  } state_t;

  localparam logic [13:0] FRAME_LAST = 14'(FRAME_BITS);
  localparam logic [13:0] SEG_LAST   = 14'(SEG_BITS);

  state_t      state;
  state_t      nextState;
  logic [7:0]  phase;      // cycles left in the current timed state
  logic [13:0] bitCnt;     // bits sent in this frame
  logic [13:0] segCnt;     // bits sent since the last segment gap
  logic [2:0]  bitIdx;     // bit position within the current byte
  logic [7:0]  shiftReg;
  logic        phaseDone;
  logic        accept;
  logic        startOk;

  // Phase timer reload value for the state being entered.
  function automatic logic [7:0] phaseLoad(input state_t s);
    case (s)
      SYNC:            phaseLoad = 8'(FM_CYCLES - 1);
      PRE_GAP,
      SEG_GAP:         phaseLoad = 8'(GAP_CYCLES - 1);
      BIT_HI,
      BIT_LO:          phaseLoad = 8'(HALF - 1);
      default:         phaseLoad = 8'd0;
    endcase
  endfunction

  assign phaseDone = (phase == 8'd0);
  assign txReady   = (state == FETCH);

  // Next-state selection from the current state and the phase timer.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    startOk   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = SYNC;
          startOk   = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
      SYNC: begin
        if (phaseDone) nextState = PRE_GAP;
        else           nextState = SYNC;
      end
      PRE_GAP: begin
        if (phaseDone) nextState = FETCH;
        else           nextState = PRE_GAP;
      end
      FETCH: begin
        if (txValid) begin
          nextState = BIT_HI;
          accept    = 1'b1;
        end else begin
          nextState = FETCH;
        end
      end
      BIT_HI: begin
        if (phaseDone) nextState = BIT_LO;
        else           nextState = BIT_HI;
      end
      BIT_LO: begin
        // Frame end wins over a segment gap when both land on the same bit.
        if (!phaseDone)                nextState = BIT_LO;
        else if (bitIdx != 3'd7)       nextState = BIT_HI;
        else if (bitCnt == FRAME_LAST) nextState = IDLE;
        else if (segCnt == SEG_LAST)   nextState = SEG_GAP;
        else                           nextState = FETCH;
      end
      SEG_GAP: begin
        if (phaseDone) nextState = FETCH;
        else           nextState = SEG_GAP;
      end
      default: nextState = IDLE;
    endcase
  end

  // State register, counters, shift register and registered line outputs.
  always_ff @(posedge clk240) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 8'd0;
      bitCnt    <= 14'd0;
      segCnt    <= 14'd0;
      bitIdx    <= 3'd0;
      shiftReg  <= 8'd0;
      dCLK      <= 1'b0;
      dDAT      <= 1'b0;
      dFM       <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= nextState;
      busy      <= (nextState != IDLE);
      frameDone <= 1'b0;

      if (nextState != state) begin
        phase <= phaseLoad(nextState);
      end else if (!phaseDone) begin
        phase <= phase - 8'd1;
      end

      case (state)
        IDLE: begin
          if (startOk) begin
            dFM      <= 1'b1;
            dDAT     <= 1'b0;
            dCLK     <= 1'b0;
            bitCnt   <= 14'd0;
            segCnt   <= 14'd0;
            bitIdx   <= 3'd0;
            underrun <= 1'b0;
          end
        end
        SYNC: begin
          if (phaseDone) dFM <= 1'b0;
        end
        FETCH: begin
          if (accept) begin
            shiftReg <= txData;
            dDAT     <= txData[7];
            dCLK     <= 1'b1;
          end else begin
            underrun <= 1'b1;
          end
        end
        BIT_HI: begin
          // dCLK falling edge: this is where a bit is counted.
          if (phaseDone) begin
            dCLK   <= 1'b0;
            bitCnt <= bitCnt + 14'd1;
            segCnt <= segCnt + 14'd1;
          end
        end
        BIT_LO: begin
          if (phaseDone) begin
            // Index wraps 7 -> 0 so it is ready for the next byte.
            bitIdx <= bitIdx + 3'd1;
            if (nextState == BIT_HI) begin
              // Rotate so bit 6 becomes the next MSB candidate.
              dDAT     <= shiftReg[6];
              shiftReg <= {shiftReg[6:0], shiftReg[7]};
              dCLK     <= 1'b1;
            end
            if (nextState == IDLE)    frameDone <= 1'b1;
            if (nextState == SEG_GAP) segCnt    <= 14'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digital_transmitter.sv
// Bench for digital_transmitter: two instances (standard timing and the
// fastest legal timing), each with a reduced frame so several whole frames
// fit in a short run. A receiver model (3-stage dCLK sync, sample on the
// detected fall) decodes the stream and compares it with the bytes fed in.
module tb_digital_transmitter;

  localparam int NI         = 2;
  localparam int FM         = 24;
  localparam int FRAME_BITS = 256;
  localparam int SEG_BITS   = 64;
  localparam int FB         = FRAME_BITS / 8;

  logic       clk240 = 1'b0;
  logic       rst       [NI];
  logic       start     [NI];
  logic [7:0] txData    [NI];
  logic       txValid   [NI];
  logic       txReady   [NI];
  logic       dCLK      [NI];
  logic       dDAT      [NI];
  logic       dFM       [NI];
  logic       busy      [NI];
  logic       frameDone [NI];
  logic       underrun  [NI];

  int checks   = 0;
  int failures = 0;

  always #2 clk240 = ~clk240;

  function automatic int halfOf(input int id);
    return (id == 0) ? 12 : 4;
  endfunction

  function automatic int gapOf(input int id);
    return (id == 0) ? 128 : 100;
  endfunction

  function automatic string tag(input string s, input int id);
    return $sformatf("%s_u%0d", s, id);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gDut
    digital_transmitter #(
      .HALF       ((g == 0) ? 12 : 4),
      .FM_CYCLES  (FM),
      .GAP_CYCLES ((g == 0) ? 128 : 100),
      .FRAME_BITS (FRAME_BITS),
      .SEG_BITS   (SEG_BITS)
    ) dut (
      .clk240    (clk240),
      .rst       (rst[g]),
      .start     (start[g]),
      .txData    (txData[g]),
      .txValid   (txValid[g]),
      .txReady   (txReady[g]),
      .dCLK      (dCLK[g]),
      .dDAT      (dDAT[g]),
      .dFM       (dFM[g]),
      .busy      (busy[g]),
      .frameDone (frameDone[g]),
      .underrun  (underrun[g])
    );
  end

  task automatic checkEq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic int outBits(input int id);
    return {25'd0, dCLK[id], dDAT[id], dFM[id], busy[id], txReady[id],
            frameDone[id], underrun[id]};
  endfunction

  // dataMode: 0 = all 8'hA5, 1 = incrementing, 2 = random bytes.
  task automatic runFrame(input int id, input int dataMode, input bit stall10,
                          input bit randDrop, input bit midStart, input bit rstMid);
    int h, g, nGaps, expEnd, obs, byteIdx, bitsDec, badBits, stallLeft, stalls;
    int rawFalls, lastFall, minSpace, hiRun, badHi, lowRun, gapsSeen, badGapPos;
    int fmHigh, badPre, firstReady, doneCnt, doneAt, badStall, badDat;
    bit s1, s2, s3, prevClk, prevDat, expUnder, stallUsed, finished, rstSent;
    logic [7:0] mem [FB];
    h = halfOf(id);
    g = gapOf(id);
    nGaps  = (FRAME_BITS - 1) / SEG_BITS;
    expEnd = FM + g + FB * (16 * h + 1) + nGaps * g;
    byteIdx = 0; bitsDec = 0; badBits = 0; stallLeft = 0; stalls = 0;
    rawFalls = 0; lastFall = -1; minSpace = 1 << 30; hiRun = 0; badHi = 0;
    lowRun = 0; gapsSeen = 0; badGapPos = 0; fmHigh = 0; badPre = 0;
    firstReady = -1; doneCnt = 0; doneAt = -1; badStall = 0; badDat = 0;
    s1 = 0; s2 = 0; s3 = 0; prevClk = 0; prevDat = 0; expUnder = 0;
    stallUsed = 0; finished = 0; rstSent = 0;
    for (int i = 0; i < FB; i++) begin
      case (dataMode)
        0:       mem[i] = 8'hA5;
        1:       mem[i] = 8'(i);
        default: mem[i] = 8'($urandom_range(0, 255));
      endcase
    end

    @(negedge clk240);
    start[id]   = 1'b1;
    txValid[id] = 1'b1;
    txData[id]  = mem[0];
    obs = -1;
    while (!finished) begin
      @(negedge clk240);
      obs++;
      start[id] = 1'b0;
      if (rstSent) begin
        checkEq(tag("rstMidOutputs", id), outBits(id), 0);
        rst[id]  = 1'b0;
        finished = 1'b1;
      end else begin
        if (obs == 0) begin
          checkEq(tag("startClearsUnderrun", id), int'(underrun[id]), 0);
          checkEq(tag("startBusy", id), int'(busy[id]), 1);
        end
        if (midStart && obs == 1001)
          checkEq(tag("midStartIgnored", id), {busy[id], dFM[id]}, 2);
        if (obs < FM + g) begin
          if (dFM[id]) fmHigh++;
          if (dFM[id] != (obs < FM) || dCLK[id] || txReady[id]) badPre++;
        end
        if (txReady[id] && firstReady < 0) firstReady = obs;
        if (stallLeft > 0 && dCLK[id]) badStall++;
        if (prevClk && !dCLK[id]) begin
          rawFalls++;
          if (lastFall >= 0 && obs - lastFall < minSpace) minSpace = obs - lastFall;
          lastFall = obs;
        end
        if (dCLK[id]) hiRun++;
        else begin
          if (hiRun > 0 && hiRun != h) badHi++;
          hiRun = 0;
        end
        if (!dCLK[id] && rawFalls > 0) lowRun++;
        else begin
          if (lowRun >= g) begin
            gapsSeen++;
            if (rawFalls % SEG_BITS != 0) badGapPos++;
          end
          lowRun = 0;
        end
        if (obs > 0 && dDAT[id] != prevDat && !(dCLK[id] && !prevClk)) badDat++;
        // Receiver model: 3-stage synchroniser, sample on detected fall.
        s3 = s2; s2 = s1; s1 = dCLK[id];
        if (s3 && !s2) begin
          if (bitsDec < FRAME_BITS && dDAT[id] != mem[bitsDec / 8][7 - (bitsDec % 8)])
            badBits++;
          bitsDec++;
        end
        prevClk = dCLK[id];
        prevDat = dDAT[id];
        if (frameDone[id]) begin
          doneCnt++;
          doneAt = obs;
          checkEq(tag("busyFallsWithDone", id), int'(busy[id]), 0);
          finished = 1'b1;
        end else if (obs > expEnd + stalls + 2000) begin
          checkEq(tag("frameTimeout", id), obs, expEnd + stalls);
          finished = 1'b1;
        end else begin
          // Byte source for the next edge.
          if (stall10 && !stallUsed && byteIdx == 10 && txReady[id]) begin
            stallUsed = 1'b1;
            stallLeft = 500;
          end
          if (stallLeft > 0)  txValid[id] = 1'b0;
          else if (randDrop)  txValid[id] = ($urandom_range(0, 3) != 0);
          else                txValid[id] = 1'b1;
          if (stallLeft > 0) stallLeft--;
          txData[id] = mem[byteIdx % FB];
          if (txReady[id]) begin
            if (txValid[id]) byteIdx++;
            else begin
              stalls++;
              expUnder = 1'b1;
            end
          end
          if (midStart && obs == 1000) start[id] = 1'b1;
          if (rstMid && bitsDec == 100) begin
            rst[id] = 1'b1;
            rstSent = 1'b1;
          end
        end
      end
    end

    if (rstSent) begin
      checkEq(tag("bitsBeforeReset", id), badBits, 0);
    end else begin
      @(negedge clk240);
      if (frameDone[id]) doneCnt++;
      checkEq(tag("idleLinesLow", id), {dCLK[id], dFM[id], busy[id]}, 0);
      checkEq(tag("fmHighCycles", id), fmHigh, FM);
      checkEq(tag("preambleShape", id), badPre, 0);
      checkEq(tag("firstReady", id), firstReady, FM + g);
      checkEq(tag("frameDoneCount", id), doneCnt, 1);
      checkEq(tag("frameDoneCycle", id), doneAt, expEnd + stalls);
      checkEq(tag("bitsDecoded", id), bitsDec, FRAME_BITS);
      checkEq(tag("rawFalls", id), rawFalls, FRAME_BITS);
      checkEq(tag("bitErrors", id), badBits, 0);
      checkEq(tag("highPhaseLen", id), badHi, 0);
      checkEq(tag("bitPeriod", id), minSpace, 2 * h);
      checkEq(tag("dDatOnlyOnRise", id), badDat, 0);
      checkEq(tag("underrunSticky", id), int'(underrun[id]), int'(expUnder));
      if (stall10) begin
        checkEq(tag("stallClkLow", id), badStall, 0);
        checkEq(tag("stallUnderrun", id), int'(underrun[id]), 1);
      end else begin
        checkEq(tag("segGapCount", id), gapsSeen, nGaps);
        checkEq(tag("segGapPosition", id), badGapPos, 0);
      end
    end
    txValid[id] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; txData[i] = 8'h00; txValid[i] = 1'b0;
    end
    repeat (3) @(negedge clk240);
    for (int i = 0; i < NI; i++) checkEq(tag("resetOutputs", i), outBits(i), 0);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(negedge clk240);
    checkEq(tag("idleAfterReset", 0), outBits(0), 0);

    fork
      runFrame(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      runFrame(1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    join
    runFrame(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame(0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    runFrame(0, 1, 1'b1, 1'b0, 1'b1, 1'b0);
    runFrame(0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    runFrame(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame(1, 2, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
